irq_axil_notifier: RTL
======================

IRQ_AXIL_NOTIFIER -- requirements
Module: irq_axil_notifier

Interface
REQ-001 Parameter num_irq_p, default 2: number of interrupt lines forwarded; legal range 1..32.
REQ-002 Parameter axil_addr_width_p, default 32: AXI-Lite address width.
REQ-003 Parameter axil_data_width_p, default 32: AXI-Lite data width; legal values 32 and 64.
REQ-004 Parameter base_addr_p, default 'h30_b000: notification address for line 0.
REQ-005 Parameter stride_p, default 4: address increment per line.
REQ-006 Parameter err_cnt_width_p, default 8: width of the error counter.
REQ-007 clk_i  in  1  sole clock; all logic rises on its positive edge.
REQ-008 reset_i  in  1  asynchronous, active-high reset.
REQ-009 irq_i  in  num_irq_p  level interrupt lines, synchronous to clk_i.
REQ-010 m_axil_aw{addr,prot,valid}  out  axil_addr_width_p/3/1; m_axil_awready  in  1: write-address channel.
REQ-011 m_axil_w{data,strb,valid}  out  axil_data_width_p/(axil_data_width_p>>3)/1; m_axil_wready  in  1: write-data channel.
REQ-012 m_axil_bresp  in  2; m_axil_bvalid  in  1; m_axil_bready  out  1: write-response channel.
REQ-013 m_axil_ar{addr,prot,valid}  out; m_axil_arready  in; m_axil_r{data,resp,valid}  in; m_axil_rready  out: read channels, unused.
REQ-014 busy_o  out  1  high whenever the FSM is not in IDLE.
REQ-015 err_cnt_o  out  err_cnt_width_p  count of error responses.

Function
REQ-016 The block SHALL keep a reported[num_irq_p] register; line i SHALL be pending when irq_i[i] != reported[i].
REQ-017 The FSM SHALL have three states: IDLE, SEND and RESP.
REQ-018 In IDLE with any line pending, a round-robin arbiter SHALL grant the lowest pending index strictly above the last granted index, wrapping to 0.
REQ-019 On that grant edge, the block SHALL latch ch and data = irq_i[ch] and enter SEND, so awvalid and wvalid both rise one cycle after the pending condition first holds in IDLE.
REQ-020 In SEND, awaddr SHALL be (base_addr_p + ch*stride_p) truncated to axil_addr_width_p; awprot SHALL be 0.
REQ-021 In SEND, wdata SHALL be data zero-extended; wstrb SHALL be all ones.
REQ-022 awvalid and wvalid SHALL each drop independently after their own handshake, and SHALL stay high and stable until that handshake.
REQ-023 The block SHALL enter RESP in the cycle after both handshakes complete; completing both handshakes in the same cycle is legal.
REQ-024 bready SHALL be 1 only in RESP.
REQ-025 In RESP, on bvalid with bresp[1]==0 (OKAY or EXOKAY), reported[ch] SHALL be set to data, and the FSM SHALL return to IDLE.
REQ-026 In RESP, on bvalid with bresp[1]==1 (SLVERR or DECERR), err_cnt SHALL increment, saturating at all ones; reported SHALL be left unchanged and the FSM SHALL return to IDLE, so the line is retried through arbitration.
REQ-027 If irq_i[ch] changes while a write is outstanding, the in-flight value SHALL complete unchanged; the line stays or becomes pending afterwards by REQ-016.
REQ-028 A toggle pair (0->1->0) that completes entirely during another line's transaction SHALL produce no write.
REQ-029 At most one transaction SHALL be outstanding at a time.
REQ-030 awvalid and wvalid SHALL never be asserted in IDLE or RESP.
REQ-031 arvalid SHALL be tied to 0, araddr and arprot to 0, and rready to 1.
REQ-032 An R beat arriving on the unused read channel SHALL be discarded.

Reset
REQ-033 While reset_i is high, the block SHALL hold: state = IDLE, reported = 0, last-granted = num_irq_p-1 (first grant favours line 0), err_cnt = 0.
REQ-034 While reset_i is high, the block SHALL drive all valid outputs and bready to 0, and busy_o to 0.
REQ-035 Reset asserted mid-transaction SHALL abandon the transaction immediately; after release, any line still high SHALL be re-reported.

Verification
REQ-036 Reset released; irq_i=2'b01 at cycle 0 -> awaddr='h30_b000, wdata=1 with awvalid at cycle 1; after OKAY bresp, reported=01 and busy_o=0.
REQ-037 irq_i 00->11 in one cycle -> two writes: line 0 ('h30_b000, data 1) first, then line 1 ('h30_b004, data 1); next 11->00 -> line 0 then line 1 again with data 0.
REQ-038 awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid holds with a stable address, RESP entered one cycle after the AW handshake.
REQ-039 bresp=2'b10 on a line-1 write -> err_cnt_o=1, write to 'h30_b004 reissued; OKAY on retry updates reported[1].
REQ-040 Line 0 toggles 0->1->0 while a line-1 write waits 5 cycles for bvalid -> no line-0 write issued.
REQ-041 reset_i pulsed during SEND with irq_i[0]=1 -> outputs 0 asynchronously; after release, a fresh write of data 1 to 'h30_b000.

Source files
------------

// File: rtl/irq_axil_notifier_if.sv
// AXI-Lite manager/subordinate bundle carrying the notifier's write and read channels.
// Master drives addresses, data, valids and response readies; slave drives the rest.
interface irq_axil_notifier_if #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32
) ();
  logic [addr_width_p-1:0]     awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid;
  logic                        awready;
  logic [data_width_p-1:0]     wdata;
  logic [(data_width_p>>3)-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [addr_width_p-1:0]     araddr;
  logic [2:0]                  arprot;
  logic                        arvalid;
  logic                        arready;
  logic [data_width_p-1:0]     rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/irq_axil_notifier.sv
// Forwards irq level changes as single AXI-Lite writes, one outstanding; AW/W rise one cycle
// after a line goes pending, each holds until its own ready; error responses retry via arbitration.
module irq_axil_notifier #(
  parameter int          num_irq_p         = 2,
  parameter int          axil_addr_width_p = 32,
  parameter int          axil_data_width_p = 32,
  parameter logic [63:0] base_addr_p       = 64'h30_b000,
  parameter int          stride_p          = 4,
  parameter int          err_cnt_width_p   = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [num_irq_p-1:0]       irq_i,
  irq_axil_notifier_if.master        m_axil,
  output logic                       busy_o,
  output logic [err_cnt_width_p-1:0] err_cnt_o
);

  localparam int ch_w_lp = (num_irq_p > 1) ? $clog2(num_irq_p) : 1;
  typedef logic [ch_w_lp-1:0] ch_t;
  typedef enum logic [1:0] {IDLE, SEND, RESP} state_e;

  state_e                     state_q, state_d;
  logic [num_irq_p-1:0]       reported_q, reported_d;
  ch_t                        last_q, last_d;
  ch_t                        ch_q, ch_d;
  logic                       data_q, data_d;
  logic                       aw_pend_q, aw_pend_d;
  logic                       w_pend_q, w_pend_d;
  logic [err_cnt_width_p-1:0] err_cnt_q, err_cnt_d;

  logic [num_irq_p-1:0] pending;
  logic                 lo_vld, hi_vld;
  ch_t                  lo_idx, hi_idx, grant_idx;
  logic [63:0]          addr_full;

  assign pending = irq_i ^ reported_q;

  // Descending scan leaves the lowest hit; the "hi" set wins so the grant rotates past last_q.
  always_comb begin
    lo_vld = 1'b0;
    hi_vld = 1'b0;
    lo_idx = '0;
    hi_idx = '0;
    for (int i = num_irq_p - 1; i >= 0; i--) begin
      if (pending[i]) begin
        lo_vld = 1'b1;
        lo_idx = ch_t'(i);
      end
      if (pending[i] && (i > int'(last_q))) begin
        hi_vld = 1'b1;
        hi_idx = ch_t'(i);
      end
    end
    grant_idx = hi_vld ? hi_idx : lo_idx;
  end

  always_comb begin
    state_d    = state_q;
    reported_d = reported_q;
    last_d     = last_q;
    ch_d       = ch_q;
    data_d     = data_q;
    aw_pend_d  = aw_pend_q;
    w_pend_d   = w_pend_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (lo_vld) begin
          state_d   = SEND;
          ch_d      = grant_idx;
          data_d    = irq_i[grant_idx];
          last_d    = grant_idx;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
        end
      end
      SEND: begin
        if (m_axil.awready) aw_pend_d = 1'b0;
        if (m_axil.wready)  w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = RESP;
      end
      RESP: begin
        if (m_axil.bvalid) begin
          state_d = IDLE;
          if (!m_axil.bresp[1]) begin
            reported_d[ch_q] = data_q;
          end else if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      reported_q <= '0;
      last_q     <= ch_t'(num_irq_p - 1);
      ch_q       <= '0;
      data_q     <= 1'b0;
      aw_pend_q  <= 1'b0;
      w_pend_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      reported_q <= reported_d;
      last_q     <= last_d;
      ch_q       <= ch_d;
      data_q     <= data_d;
      aw_pend_q  <= aw_pend_d;
      w_pend_q   <= w_pend_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign addr_full      = base_addr_p + (64'(ch_q) * 64'(stride_p));
  assign m_axil.awaddr  = addr_full[axil_addr_width_p-1:0];
  assign m_axil.awprot  = 3'b000;
  assign m_axil.awvalid = (state_q == SEND) && aw_pend_q;
  assign m_axil.wdata   = {{(axil_data_width_p-1){1'b0}}, data_q};
  assign m_axil.wstrb   = '1;
  assign m_axil.wvalid  = (state_q == SEND) && w_pend_q;
  assign m_axil.bready  = (state_q == RESP);
  assign m_axil.araddr  = '0;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.arvalid = 1'b0;
  assign m_axil.rready  = 1'b1;

  assign busy_o    = (state_q != IDLE);
  assign err_cnt_o = err_cnt_q;

  // Read channel is never used; R beats are accepted and dropped.
  logic unused_rd;
  assign unused_rd = ^{m_axil.arready, m_axil.rvalid, m_axil.rdata, m_axil.rresp, m_axil.bresp[0]};

endmodule
